vinsn_launcher: RTL and testbench
=================================

Name: vinsn_launcher

Overview:
- Sits directly downstream of the vector instruction decoder. Consumes its registered `issue_req_t` stream over a valid/ready handshake.
- Tracks in-flight vector instructions in a small slot table (scoreboard) and stalls on RAW/WAW/WAR register hazards.
- Dispatches each instruction to the arithmetic unit or the store unit, frees its slot on completion and reports completion (insn_id) back to the scalar core.

Parameters:
- NrSlots, 4, number of in-flight instruction slots; power of two, ≥2.
- SlotIdW, $clog2(NrSlots), width of slot tag (derived, not overridden).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous, active-high reset
- req_valid_i  in  1  decoder request valid
- req_ready_o  out  1  launcher accepts request this cycle
- issue_req_i  in  $bits(issue_req_t)  decoded request (vs1, vs2, vd, use_vs, vop, vew, vlB, scalar_op, insn_id, flip_bit)
- arith_valid_o  out  1  request to arithmetic unit valid
- arith_ready_i  in  1  arithmetic unit accepts
- arith_req_o  out  $bits(unit_req_t)  issue_req plus slot tag
- store_valid_o  out  1  request to store unit valid
- store_ready_i  in  1  store unit accepts
- store_req_o  out  $bits(unit_req_t)  issue_req plus slot tag
- arith_done_valid_i  in  1  arithmetic completion
- arith_done_slot_i  in  SlotIdW  completing slot
- store_done_valid_i  in  1  store completion
- store_done_slot_i  in  SlotIdW  completing slot
- store_done_ready_o  out  1  store completion accepted (arith always accepted)
- commit_valid_o  out  1  one instruction completed
- commit_id_o  out  $bits(insn_id_t)  insn_id of completed instruction

Behaviour:
- Reset (rst_i high at posedge): all slots invalid; arith_valid_o, store_valid_o, commit_valid_o = 0. Data outputs undefined. Reset mid-operation discards in-flight slots and pending unit requests without commit.
- Routing: vop==VSE → store unit. No slot writes a register. All other vops → arith unit. Slot writes vd.
- Source reads: vs1 is read iff use_vs[0]; vs2 is read iff use_vs[1]. For stores, vs1 carries vs3.
- Slot contents: valid, insn_id, flip_bit, vd, writes flag, read regs (vs1/vs2 with enables).
- Hazards are checked against all valid slots:
  - RAW: new read reg == slot vd with writes.
  - WAW: new vd == slot vd with writes.
  - WAR: new vd == slot read reg.
- req_ready_o = no hazard AND a free slot exists AND the target output register is empty or being consumed this cycle (valid && ready).
  - Purely combinational from registered state and unit ready. Does not depend on req_valid_i.
- Accept (req_valid_i && req_ready_o):
  - Allocate the lowest-index free slot.
  - Load the target output register, so *_valid_o rises the next cycle.
  - The output holds stable until ready. Latency from accept to unit valid is 1 cycle.
- Completion:
  - A done pulse frees its slot at the next posedge.
  - A slot freed this cycle is still treated as occupied for hazard/full checks this cycle. This is conservative and there is no bypass.
  - Allocation and free of different slots in the same cycle are both honoured.
- Dual completion: arith has priority. store_done_ready_o = !arith_done_valid_i, and the store unit holds its done until accepted.
- Commit:
  - commit_valid_o is registered, asserted exactly one cycle after an accepted done, for one cycle.
  - commit_id_o equals the freed slot's insn_id.
  - There is no backpressure from the scalar core.
- Full: with NrSlots valid slots, req_ready_o = 0. It rises the cycle after a completion frees a slot, provided there is no hazard.
- Order: dispatch is in program order; completion may be out of order across units.
- A done on an invalid slot is a protocol error. The block asserts on it in simulation and otherwise ignores it.

Decomposition:
- rvv_pkg additions:
  - slot_id_t (SlotIdW bits).
  - unit_req_t (struct: issue_req_t req; slot_id_t slot).
  - Default NrSlots constant.
- issue_req_t, insn_id_t and vop encodings are reused unchanged.
- Sub-module vinsn_scoreboard: slot table, hazard compare, lowest-free allocator, free logic.
- vinsn_launcher keeps output registers, routing and commit.

Test Plan:
- Single VADD vd=3 vs1=1 vs2=2 → req_ready_o=1; arith_valid_o=1 next cycle with slot 0. After arith_done slot 0, commit_valid_o=1 one cycle later with matching insn_id.
- RAW: VADD vd=4, then VSE vs1=4 → second request stalls (req_ready_o=0) until arith_done slot 0; accepted the cycle after; store_req_o slot=0 (reused).
- WAR: VSE vs1=5 in flight, then VADD vd=5 → stall until store done. VADD vs1=5 (no write) is accepted immediately.
- Full: 4 independent VADDs (vd 1..4) with arith_ready_i=1 and no done → 5th stalls. Done slot 2 → 5th accepted next cycle into slot 2.
- Backpressure: arith_ready_i=0 for 3 cycles → arith_valid_o and arith_req_o stable. Second arith request stalls; a store request is accepted.
- Simultaneous done on slots 0 (arith) and 1 (store) → store_done_ready_o=0. Commits for slot 0 then slot 1 on consecutive cycles. Reset asserted mid-flight → all valids 0 and 4 requests accepted afterwards.

Source files
------------

// File: rtl/vinsn_launcher_pkg.sv
// Shared types for the vector instruction launcher: decoded request, unit request and slot entry.
package vinsn_launcher_pkg;

   localparam int unsigned NrSlotsDefault = 4;
   localparam int unsigned SlotIdW        = $clog2(NrSlotsDefault);

   typedef logic [4:0]         vreg_t;
   typedef logic [4:0]         insn_id_t;
   typedef logic [SlotIdW-1:0] slot_id_t;

   typedef enum logic [2:0] {
      VADD = 3'd0,
      VSUB = 3'd1,
      VMUL = 3'd2,
      VAND = 3'd3,
      VOR  = 3'd4,
      VXOR = 3'd5,
      VMV  = 3'd6,
      VSE  = 3'd7
   } vop_e;

   typedef enum logic [1:0] {EW8, EW16, EW32, EW64} vew_e;

   typedef struct packed {
      vreg_t       vs1;
      vreg_t       vs2;
      vreg_t       vd;
      logic [1:0]  use_vs;
      vop_e        vop;
      vew_e        vew;
      logic [7:0]  vlB;
      logic [31:0] scalar_op;
      insn_id_t    insn_id;
      logic        flip_bit;
   } issue_req_t;

   typedef struct packed {
      issue_req_t req;
      slot_id_t   slot;
   } unit_req_t;

   typedef struct packed {
      insn_id_t   insn_id;
      vreg_t      vd;
      logic       writes;
      vreg_t      vs1;
      vreg_t      vs2;
      logic [1:0] rd_en;
   } slot_t;

endpackage

// File: rtl/vinsn_launcher_scoreboard.sv
// In-flight slot table: register hazard detection, lowest-free allocation and completion free.
module vinsn_scoreboard
   import vinsn_launcher_pkg::*;
#(
   parameter  int unsigned NrSlots = NrSlotsDefault,
   localparam int unsigned SlotW   = $clog2(NrSlots)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  vreg_t            chk_vs1_i,
   input  vreg_t            chk_vs2_i,
   input  vreg_t            chk_vd_i,
   input  logic [1:0]       chk_use_vs_i,
   input  logic             chk_writes_i,
   input  insn_id_t         chk_id_i,
   output logic             hazard_o,
   output logic             full_o,
   input  logic             alloc_i,
   output logic [SlotW-1:0] alloc_slot_o,
   input  logic             free_i,
   input  logic [SlotW-1:0] free_slot_i,
   output logic             free_hit_o,
   output insn_id_t         free_id_o
);

   logic [NrSlots-1:0] valid_q, valid_d;
   slot_t [NrSlots-1:0] slot_q, slot_d;
   logic found;

   // Hazards use registered occupancy only: a slot freed this cycle still blocks.
   always_comb begin
      hazard_o = 1'b0;
      for (int unsigned i = 0; i < NrSlots; i++) begin
         if (valid_q[i]) begin
            if (slot_q[i].writes &&
                ((chk_use_vs_i[0] && chk_vs1_i == slot_q[i].vd) ||
                 (chk_use_vs_i[1] && chk_vs2_i == slot_q[i].vd)))
               hazard_o = 1'b1;
            if (chk_writes_i && slot_q[i].writes && chk_vd_i == slot_q[i].vd)
               hazard_o = 1'b1;
            if (chk_writes_i &&
                ((slot_q[i].rd_en[0] && slot_q[i].vs1 == chk_vd_i) ||
                 (slot_q[i].rd_en[1] && slot_q[i].vs2 == chk_vd_i)))
               hazard_o = 1'b1;
         end
      end
   end

   always_comb begin
      alloc_slot_o = '0;
      found        = 1'b0;
      for (int unsigned i = 0; i < NrSlots; i++) begin
         if (!found && !valid_q[i]) begin
            alloc_slot_o = SlotW'(i);
            found        = 1'b1;
         end
      end
   end

   assign full_o     = &valid_q;
   assign free_hit_o = valid_q[free_slot_i];
   assign free_id_o  = slot_q[free_slot_i].insn_id;

   always_comb begin
      valid_d = valid_q;
      slot_d  = slot_q;
      if (free_i && free_hit_o) valid_d[free_slot_i] = 1'b0;
      if (alloc_i) begin
         valid_d[alloc_slot_o]        = 1'b1;
         slot_d[alloc_slot_o].insn_id = chk_id_i;
         slot_d[alloc_slot_o].vd      = chk_vd_i;
         slot_d[alloc_slot_o].writes  = chk_writes_i;
         slot_d[alloc_slot_o].vs1     = chk_vs1_i;
         slot_d[alloc_slot_o].vs2     = chk_vs2_i;
         slot_d[alloc_slot_o].rd_en   = chk_use_vs_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) valid_q <= '0;
      else       valid_q <= valid_d;
   end

   always_ff @(posedge clk_i) begin
      slot_q <= slot_d;
   end

   free_on_valid_slot: assert property (@(posedge clk_i) disable iff (rst_i)
      free_i |-> valid_q[free_slot_i]);

endmodule

// File: rtl/vinsn_launcher.sv
// Vector instruction launcher: hazard-checked acceptance, unit dispatch registers and commit reporting.
module vinsn_launcher
   import vinsn_launcher_pkg::*;
#(
   parameter  int unsigned NrSlots = NrSlotsDefault,
   localparam int unsigned SlotW   = $clog2(NrSlots)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             req_valid_i,
   output logic             req_ready_o,
   input  issue_req_t       issue_req_i,
   output logic             arith_valid_o,
   input  logic             arith_ready_i,
   output unit_req_t        arith_req_o,
   output logic             store_valid_o,
   input  logic             store_ready_i,
   output unit_req_t        store_req_o,
   input  logic             arith_done_valid_i,
   input  logic [SlotW-1:0] arith_done_slot_i,
   input  logic             store_done_valid_i,
   input  logic [SlotW-1:0] store_done_slot_i,
   output logic             store_done_ready_o,
   output logic             commit_valid_o,
   output insn_id_t         commit_id_o
);

   logic             to_store, tgt_free, hazard, full, accept;
   logic             free, free_hit;
   logic [SlotW-1:0] alloc_slot, free_slot;
   insn_id_t         free_id;

   logic      arith_valid_q, arith_valid_d, store_valid_q, store_valid_d;
   unit_req_t arith_req_q, arith_req_d, store_req_q, store_req_d;
   logic      commit_valid_q, commit_valid_d;
   insn_id_t  commit_id_q, commit_id_d;

   assign to_store    = (issue_req_i.vop == VSE);
   assign tgt_free    = to_store ? (!store_valid_q || store_ready_i)
                                 : (!arith_valid_q || arith_ready_i);
   assign req_ready_o = !hazard && !full && tgt_free;
   assign accept      = req_valid_i && req_ready_o;

   // Arith completions always win; the store unit holds its done until accepted.
   assign store_done_ready_o = !arith_done_valid_i;
   assign free      = arith_done_valid_i || store_done_valid_i;
   assign free_slot = arith_done_valid_i ? arith_done_slot_i : store_done_slot_i;

   vinsn_scoreboard #(.NrSlots(NrSlots)) i_scoreboard (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .chk_vs1_i    (issue_req_i.vs1),
      .chk_vs2_i    (issue_req_i.vs2),
      .chk_vd_i     (issue_req_i.vd),
      .chk_use_vs_i (issue_req_i.use_vs),
      .chk_writes_i (!to_store),
      .chk_id_i     (issue_req_i.insn_id),
      .hazard_o     (hazard),
      .full_o       (full),
      .alloc_i      (accept),
      .alloc_slot_o (alloc_slot),
      .free_i       (free),
      .free_slot_i  (free_slot),
      .free_hit_o   (free_hit),
      .free_id_o    (free_id)
   );

   always_comb begin
      arith_valid_d  = arith_valid_q && !arith_ready_i;
      arith_req_d    = arith_req_q;
      store_valid_d  = store_valid_q && !store_ready_i;
      store_req_d    = store_req_q;
      commit_valid_d = free && free_hit;
      commit_id_d    = free_id;
      if (accept) begin
         if (to_store) begin
            store_valid_d = 1'b1;
            store_req_d   = '{req: issue_req_i, slot: alloc_slot};
         end else begin
            arith_valid_d = 1'b1;
            arith_req_d   = '{req: issue_req_i, slot: alloc_slot};
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         arith_valid_q  <= 1'b0;
         store_valid_q  <= 1'b0;
         commit_valid_q <= 1'b0;
      end else begin
         arith_valid_q  <= arith_valid_d;
         store_valid_q  <= store_valid_d;
         commit_valid_q <= commit_valid_d;
      end
   end

   always_ff @(posedge clk_i) begin
      arith_req_q <= arith_req_d;
      store_req_q <= store_req_d;
      commit_id_q <= commit_id_d;
   end

   assign arith_valid_o  = arith_valid_q;
   assign arith_req_o    = arith_req_q;
   assign store_valid_o  = store_valid_q;
   assign store_req_o    = store_req_q;
   assign commit_valid_o = commit_valid_q;
   assign commit_id_o    = commit_id_q;

endmodule

// File: tb/tb_vinsn_launcher.sv
// Randomized bench for vinsn_launcher against a register-busy-set reference model.
module tb_vinsn_launcher;
   import vinsn_launcher_pkg::*;

   localparam int NS = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic       req_valid;
   logic       req_ready;
   issue_req_t issue_req;
   logic       arith_valid, arith_ready, store_valid, store_ready;
   unit_req_t  arith_req, store_req;
   logic       arith_done_valid, store_done_valid, store_done_ready;
   slot_id_t   arith_done_slot, store_done_slot;
   logic       commit_valid;
   insn_id_t   commit_id;

   always #5 clk = ~clk;

   vinsn_launcher #(.NrSlots(NS)) dut (
      .clk_i              (clk),
      .rst_i              (rst),
      .req_valid_i        (req_valid),
      .req_ready_o        (req_ready),
      .issue_req_i        (issue_req),
      .arith_valid_o      (arith_valid),
      .arith_ready_i      (arith_ready),
      .arith_req_o        (arith_req),
      .store_valid_o      (store_valid),
      .store_ready_i      (store_ready),
      .store_req_o        (store_req),
      .arith_done_valid_i (arith_done_valid),
      .arith_done_slot_i  (arith_done_slot),
      .store_done_valid_i (store_done_valid),
      .store_done_slot_i  (store_done_slot),
      .store_done_ready_o (store_done_ready),
      .commit_valid_o     (commit_valid),
      .commit_id_o        (commit_id)
   );

   int n_checks = 0;
   int n_err    = 0;

   bit m_v[NS];
   int m_id[NS], m_vd[NS], m_r1[NS], m_r2[NS];
   bit m_wr[NS], m_e1[NS], m_e2[NS];
   bit        ma_v, ms_v, mc_v;
   unit_req_t ma_q, ms_q;
   int        mc_id;
   int        a_inflight[$], s_inflight[$];
   bit        sd_pend;
   int        sd_slot;
   int        id_ctr = 0;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Decide acceptability from the sets of registers busy being written / read.
   function automatic bit exp_ready();
      bit wr_busy[32];
      bit rd_busy[32];
      int used = 0;
      bit st, haz;
      for (int i = 0; i < NS; i++) begin
         if (m_v[i]) begin
            used++;
            if (m_wr[i]) wr_busy[m_vd[i]] = 1'b1;
            if (m_e1[i]) rd_busy[m_r1[i]] = 1'b1;
            if (m_e2[i]) rd_busy[m_r2[i]] = 1'b1;
         end
      end
      st  = (issue_req.vop == VSE);
      haz = (issue_req.use_vs[0] && wr_busy[issue_req.vs1]) ||
            (issue_req.use_vs[1] && wr_busy[issue_req.vs2]) ||
            (!st && (wr_busy[issue_req.vd] || rd_busy[issue_req.vd]));
      return !haz && (used < NS) && (st ? (!ms_v || store_ready) : (!ma_v || arith_ready));
   endfunction

   task automatic check_regs();
      check("arith_valid", arith_valid, ma_v);
      if (ma_v) check("arith_req", arith_req, ma_q);
      check("store_valid", store_valid, ms_v);
      if (ms_v) check("store_req", store_req, ms_q);
      check("commit_valid", commit_valid, mc_v);
      if (mc_v) check("commit_id", commit_id, mc_id);
   endtask

   task automatic model_clear();
      for (int i = 0; i < NS; i++) m_v[i] = 1'b0;
      ma_v = 0; ms_v = 0; mc_v = 0; sd_pend = 0;
      a_inflight.delete();
      s_inflight.delete();
   endtask

   task automatic set_idle();
      req_valid        = 1'b0;
      issue_req        = '0;
      arith_ready      = 1'b0;
      store_ready      = 1'b0;
      arith_done_valid = 1'b0;
      arith_done_slot  = '0;
      store_done_valid = sd_pend;
      store_done_slot  = slot_id_t'(sd_slot);
   endtask

   task automatic tick();
      bit rdy;
      int fs, alloc;
      #1;
      rdy = 1'b0;
      if (!rst) begin
         rdy = exp_ready();
         check("req_ready", req_ready, rdy);
      end
      check("store_done_ready", store_done_ready, !arith_done_valid);
      if (rst) begin
         model_clear();
      end else begin
         alloc = -1;
         for (int i = 0; i < NS; i++) if (!m_v[i] && alloc < 0) alloc = i;
         fs = -1;
         if (arith_done_valid) begin
            fs = int'(arith_done_slot);
            foreach (a_inflight[k]) if (a_inflight[k] == fs) begin a_inflight.delete(k); break; end
         end else if (store_done_valid) begin
            fs = int'(store_done_slot);
            foreach (s_inflight[k]) if (s_inflight[k] == fs) begin s_inflight.delete(k); break; end
            sd_pend = 1'b0;
         end
         mc_v = 1'b0;
         if (fs >= 0 && m_v[fs]) begin
            mc_v = 1'b1; mc_id = m_id[fs]; m_v[fs] = 1'b0;
         end
         if (ma_v && arith_ready) begin a_inflight.push_back(int'(ma_q.slot)); ma_v = 1'b0; end
         if (ms_v && store_ready) begin s_inflight.push_back(int'(ms_q.slot)); ms_v = 1'b0; end
         if (req_valid && rdy) begin
            m_v[alloc]  = 1'b1;
            m_id[alloc] = int'(issue_req.insn_id);
            m_vd[alloc] = int'(issue_req.vd);
            m_wr[alloc] = (issue_req.vop != VSE);
            m_r1[alloc] = int'(issue_req.vs1);
            m_r2[alloc] = int'(issue_req.vs2);
            m_e1[alloc] = issue_req.use_vs[0];
            m_e2[alloc] = issue_req.use_vs[1];
            if (issue_req.vop == VSE) begin
               ms_v = 1'b1; ms_q = '{req: issue_req, slot: slot_id_t'(alloc)};
            end else begin
               ma_v = 1'b1; ma_q = '{req: issue_req, slot: slot_id_t'(alloc)};
            end
         end
      end
      @(posedge clk);
      @(negedge clk);
      check_regs();
   endtask

   task automatic gen_random(input int p_req, input int p_ar, input int p_sr, input int p_done);
      req_valid           = ($urandom_range(99) < p_req);
      issue_req.vs1       = vreg_t'($urandom_range(7));
      issue_req.vs2       = vreg_t'($urandom_range(7));
      issue_req.vd        = vreg_t'($urandom_range(7));
      issue_req.use_vs    = 2'($urandom_range(3));
      issue_req.vop       = ($urandom_range(3) == 0) ? VSE : vop_e'(3'($urandom_range(6)));
      issue_req.vew       = vew_e'(2'($urandom_range(3)));
      issue_req.vlB       = 8'($urandom);
      issue_req.scalar_op = $urandom;
      issue_req.insn_id   = insn_id_t'(id_ctr);
      issue_req.flip_bit  = 1'($urandom_range(1));
      id_ctr++;
      arith_ready = ($urandom_range(99) < p_ar);
      store_ready = ($urandom_range(99) < p_sr);
      arith_done_valid = 1'b0;
      arith_done_slot  = slot_id_t'($urandom_range(NS - 1));
      if (a_inflight.size() > 0 && $urandom_range(99) < p_done) begin
         arith_done_valid = 1'b1;
         arith_done_slot  = slot_id_t'(a_inflight[$urandom_range(a_inflight.size() - 1)]);
      end
      if (!sd_pend && s_inflight.size() > 0 && $urandom_range(99) < p_done) begin
         sd_pend = 1'b1;
         sd_slot = s_inflight[$urandom_range(s_inflight.size() - 1)];
      end
      store_done_valid = sd_pend;
      store_done_slot  = sd_pend ? slot_id_t'(sd_slot) : slot_id_t'($urandom_range(NS - 1));
   endtask

   task automatic do_reset();
      rst = 1'b1;
      model_clear();
      set_idle();
      tick();
      tick();
      rst = 1'b0;
   endtask

   initial begin
      sd_pend = 1'b0;
      sd_slot = 0;
      do_reset();

      // Single VADD through dispatch, completion and commit.
      set_idle();
      req_valid   = 1'b1;
      issue_req   = '{vs1: 5'd1, vs2: 5'd2, vd: 5'd3, use_vs: 2'b11, vop: VADD, vew: EW32,
                      vlB: 8'd16, scalar_op: 32'h0, insn_id: 5'd9, flip_bit: 1'b0};
      arith_ready = 1'b1;
      tick();
      check("first_slot", 128'(arith_req.slot), 128'(0));
      set_idle(); arith_ready = 1'b1; tick();
      set_idle(); arith_done_valid = 1'b1; arith_done_slot = '0; tick();
      check("first_commit_id", 128'(commit_id), 128'(9));
      set_idle(); tick();

      for (int i = 0; i < 400; i++) begin gen_random(60, 70, 70, 30); tick(); end
      for (int i = 0; i < 150; i++) begin gen_random(80, 90, 90, 0);  tick(); end
      for (int i = 0; i < 150; i++) begin gen_random(70, 20, 80, 30); tick(); end
      for (int i = 0; i < 20;  i++) begin gen_random(90, 80, 80, 0);  tick(); end
      do_reset();
      for (int i = 0; i < 400; i++) begin gen_random(70, 60, 60, 40); tick(); end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
